// File: rtl/gost34_12_2015_magma_core_if.sv
// Block-in / result-out handshake bundle for gost34_12_2015_magma_core.
// The core connects via the slave modport; the block supplier and result consumer use master.
interface gost34_12_2015_magma_core_if;
  logic         s_valid;
  logic         s_ready;
  logic [255:0] s_key;
  logic         s_decrypt;
  logic [63:0]  s_data;
  logic         m_valid;
  logic         m_ready;
  logic [63:0]  m_data;

  modport slave (
    input  s_valid, s_key, s_decrypt, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_key, s_decrypt, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/gost34_12_2015_magma_core.sv
// GOST R 34.12-2015 Magma (64-bit block) iterative core, UNROLL rounds per clock.
// Define GOST_MAGMA_DEFAULT_SBOX_EN to hardwire the tc26-Z S-box and ignore the sbox port.
module gost34_12_2015_magma_core #(
  parameter int UNROLL = 1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [511:0]                sbox,
  gost34_12_2015_magma_core_if.slave  bus
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("gost34_12_2015_magma_core: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [5:0] LAST_BASE = 6'(32 - UNROLL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_armed;
  logic [5:0]    r_round;
  logic [31:0]   r_a1;
  logic [31:0]   r_a0;
  logic [255:0]  r_key;
  logic          r_dec;
  logic [63:0]   r_result;

  logic [511:0]  w_sbox;
  logic          w_accept;
  logic          w_last;
  logic [31:0]   w_a1;
  logic [31:0]   w_a0;
  logic [31:0]   w_f;
  logic [31:0]   w_tmp;
  logic [4:0]    w_rnd;

`ifdef GOST_MAGMA_DEFAULT_SBOX_EN
  // id-tc26-gost-28147-param-Z: slice i holds pi_i, entry 15 in the top nibble.
  localparam logic [511:0] TC26_Z = {
    64'h1F307D8E9B5A264C, 64'hF0DB74E1C5A93286,
    64'h069C471EDAF2853B, 64'hB9E35A076F4D128C,
    64'hC24BE390D618A5F7, 64'h0E34187BAC296FD5,
    64'h73AD0B4FC19652E8, 64'h2BC96AF43850DE71
  };
  assign w_sbox = TC26_Z;
`else
  assign w_sbox = sbox;
`endif

  // g[k](a): add key mod 2^32, substitute each nibble, rotate left by 11.
  function automatic logic [31:0] f_g(input logic [31:0] a, input logic [31:0] k,
                                      input logic [511:0] tbl);
    logic [31:0] t;
    logic [31:0] s;
    logic [63:0] row;
    t = a + k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      row          = tbl[511 - 64*i -: 64];
      s[4*i +: 4]  = row[{t[4*i +: 4], 2'b00} +: 4];
    end
    return {s[20:0], s[31:21]};
  endfunction

  // Rounds 0..23 (encrypt) or 0..7 (decrypt) walk K1..K8 forward; the rest walk K8..K1.
  function automatic logic [31:0] f_round_key(input logic [255:0] key, input logic [4:0] rnd,
                                              input logic dec);
    logic       fwd;
    logic [2:0] idx;
    fwd = dec ? (rnd < 5'd8) : (rnd < 5'd24);
    idx = fwd ? rnd[2:0] : ~rnd[2:0];
    return key[{~idx, 5'b00000} +: 32];
  endfunction

  // NOTE: blocking assignments here are deliberate: they chain UNROLL rounds
  // combinationally within one cycle, each round seeing the previous one's result.
  always_comb begin
    w_a1  = r_a1;
    w_a0  = r_a0;
    w_f   = '0;
    w_tmp = '0;
    w_rnd = '0;
    for (int u = 0; u < UNROLL; u++) begin
      w_rnd = 5'(r_round) + 5'(u);
      w_f   = f_g(w_a0, f_round_key(r_key, w_rnd, r_dec), w_sbox);
      if (w_rnd == 5'd31) begin
        w_a1 = w_f ^ w_a1;
      end else begin
        w_tmp = w_a0;
        w_a0  = w_f ^ w_a1;
        w_a1  = w_tmp;
      end
    end
  end

  assign w_accept = (r_state == IDLE) && r_armed && bus.s_valid;
  assign w_last   = (r_state == RUN) && (r_round == LAST_BASE);

  // r_armed keeps s_ready low until the first clock edge after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_armed <= 1'b1;
    end
  end

  // NOTE: every output and next-state value gets a default before the case,
  // so no path through this block can leave a signal unassigned (no latches).
  always_comb begin
    w_state_next = r_state;
    bus.s_ready  = 1'b0;
    bus.m_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        bus.s_ready = r_armed;
        if (w_accept) w_state_next = RUN;
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        bus.m_valid = 1'b1;
        if (bus.m_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: key and block registers are cleared on reset so a discarded block
  // leaves no key material behind; nothing here is a RAM, so this is cheap.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_round  <= '0;
      r_a1     <= '0;
      r_a0     <= '0;
      r_key    <= '0;
      r_dec    <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a1    <= bus.s_data[63:32];
      r_a0    <= bus.s_data[31:0];
      r_key   <= bus.s_key;
      r_dec   <= bus.s_decrypt;
      r_round <= '0;
    end else if (r_state == RUN) begin
      r_a1    <= w_a1;
      r_a0    <= w_a0;
      r_round <= r_round + 6'(UNROLL);
      if (w_last) r_result <= {w_a1, w_a0};
    end
  end

  assign bus.m_data = r_result;

endmodule

// File: tb/tb_gost34_12_2015_magma_core.sv
// Self-checking bench: four cores (UNROLL 1/2/4/8) driven in lockstep, checked against
// a behavioural Magma model plus the GOST 34.12-2015 known-answer vector.
module tb_gost34_12_2015_magma_core;
  localparam int N_DUT = 4;
  localparam logic [255:0] KAT_KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0]  KAT_PT  = 64'hfedcba9876543210;
  localparam logic [63:0]  KAT_CT  = 64'h4ee901e5c2d8ca3d;

  // tc26-Z permutations pi0..pi7 in natural order, entry j = pi_i(j).
  localparam int PI [8][16] = '{
    '{12, 4, 6, 2,10, 5,11, 9,14, 8,13, 7, 0, 3,15, 1},
    '{ 6, 8, 2, 3, 9,10, 5,12, 1,14, 4, 7,11,13, 0,15},
    '{11, 3, 5, 8, 2,15,10,13,14, 1, 7, 4,12, 9, 6, 0},
    '{12, 8, 2, 1,13, 4,15, 6, 7, 0,10, 5, 3,14, 9,11},
    '{ 7,15, 5,10, 8, 1, 6,13, 0, 9, 3,14,11, 4, 2,12},
    '{ 5,13,15, 6, 9, 2,12,10,11, 7, 8, 1, 4, 3,14, 0},
    '{ 8,14, 2, 5, 6, 9, 1,12,15, 4,11, 0,13,10, 3, 7},
    '{ 1, 7,14,13, 0, 5, 8, 3, 4,15,10, 6, 9,12,11, 2}
  };

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [511:0] sbox = '0;
  logic         s_valid = 1'b0;
  logic [255:0] s_key = '0;
  logic         s_decrypt = 1'b0;
  logic [63:0]  s_data = '0;
  logic         m_ready = 1'b0;

  logic [N_DUT-1:0]       sr;
  logic [N_DUT-1:0]       mv;
  logic [N_DUT-1:0][63:0] md;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    gost34_12_2015_magma_core_if bus ();
    assign bus.s_valid   = s_valid;
    assign bus.s_key     = s_key;
    assign bus.s_decrypt = s_decrypt;
    assign bus.s_data    = s_data;
    assign bus.m_ready   = m_ready;
    assign sr[g]         = bus.s_ready;
    assign mv[g]         = bus.m_valid;
    assign md[g]         = bus.m_data;

    gost34_12_2015_magma_core #(.UNROLL(1 << g)) u_dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .sbox    (sbox),
      .bus     (bus)
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] tc26_z_table();
    logic [511:0] tbl;
    tbl = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 16; j++)
        tbl[448 - 64*i + 4*j +: 4] = 4'(PI[i][j]);
    return tbl;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Reference g: look up each nibble arithmetically, then rotate by 11.
  function automatic logic [31:0] ref_g(input logic [31:0] a, input logic [31:0] k,
                                        input logic [511:0] tbl);
    logic [31:0] t;
    logic [31:0] s;
    int          n;
    t = a + k;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      n = int'((t >> (4*i)) & 32'hf);
      s = s | (32'(tbl[448 - 64*i + 4*n +: 4]) << (4*i));
    end
    return (s << 11) | (s >> 21);
  endfunction

  function automatic logic [63:0] ref_magma(input logic [255:0] key, input logic [63:0] blk,
                                            input logic dec, input logic [511:0] tbl);
    logic [31:0] kw [8];
    int          order [$];
    logic [31:0] a1, a0, t;
    for (int i = 0; i < 8; i++) kw[i] = key[255 - 32*i -: 32];
    if (!dec) begin
      for (int p = 0; p < 3; p++) for (int i = 0; i < 8; i++) order.push_back(i);
      for (int i = 7; i >= 0; i--) order.push_back(i);
    end else begin
      for (int i = 0; i < 8; i++) order.push_back(i);
      for (int p = 0; p < 3; p++) for (int i = 7; i >= 0; i--) order.push_back(i);
    end
    a1 = blk[63:32];
    a0 = blk[31:0];
    for (int r = 0; r < 31; r++) begin
      t  = a0;
      a0 = ref_g(a0, kw[order[r]], tbl) ^ a1;
      a1 = t;
    end
    a1 = ref_g(a0, kw[order[31]], tbl) ^ a1;
    return {a1, a0};
  endfunction

  // Accept one block on all cores, scramble inputs while in flight, then
  // check each core's latency, result and post-handshake hold.
  task automatic run_block(input string tag, input logic [255:0] key, input logic [63:0] data,
                           input logic dec, input logic [63:0] exp);
    int          lat [N_DUT];
    logic [63:0] got [N_DUT];
    for (int i = 0; i < N_DUT; i++) begin
      lat[i] = -1;
      got[i] = '0;
    end
    @(negedge aclk);
    check({tag, " s_ready before accept"}, 64'(sr), 64'hf);
    s_key = key; s_data = data; s_decrypt = dec; s_valid = 1'b1; m_ready = 1'b1;
    @(posedge aclk);
    #1;
    s_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge aclk);
      #1;
      s_key = rnd256(); s_data = {$urandom, $urandom}; s_decrypt = 1'($urandom);
      for (int i = 0; i < N_DUT; i++)
        if (mv[i] && lat[i] < 0) begin
          lat[i] = k;
          got[i] = md[i];
        end
    end
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("%s latency U%0d", tag, 1 << i), 64'(lat[i]), 64'(32 >> i));
      check($sformatf("%s data U%0d", tag, 1 << i), got[i], exp);
      check($sformatf("%s idle hold U%0d", tag, 1 << i), md[i], exp);
    end
    check({tag, " m_valid low after handshake"}, 64'(mv), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [511:0] z_tbl;
    logic [255:0] key;
    logic [63:0]  blk;
    logic         dec;
    logic [N_DUT-1:0] seen_mv;

    z_tbl = tc26_z_table();
    sbox  = z_tbl;

    // Reset state, and s_ready rising only on the first edge after release.
    #12;
    check("reset s_ready", 64'(sr), 64'h0);
    check("reset m_valid", 64'(mv), 64'h0);
    for (int i = 0; i < N_DUT; i++) check($sformatf("reset m_data U%0d", 1 << i), md[i], 64'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("s_ready low before first edge", 64'(sr), 64'h0);
    @(posedge aclk);
    #1;
    check("s_ready after first edge", 64'(sr), 64'hf);

    // Known-answer encrypt and decrypt.
    run_block("kat enc", KAT_KEY, KAT_PT, 1'b0, KAT_CT);
    run_block("kat dec", KAT_KEY, KAT_CT, 1'b1, KAT_PT);

    // Random key/data/mode under a random substitution table.
    sbox = rnd512();
    for (int n = 0; n < 6; n++) begin
      key = rnd256();
      blk = {$urandom, $urandom};
      dec = 1'($urandom);
      run_block($sformatf("rand%0d", n), key, blk, dec, ref_magma(key, blk, dec, sbox));
    end
    sbox = z_tbl;

    // DONE held by backpressure while s_valid and s_data toggle.
    @(negedge aclk);
    s_key = KAT_KEY; s_data = KAT_PT; s_decrypt = 1'b0; s_valid = 1'b1; m_ready = 1'b0;
    @(posedge aclk);
    #1;
    for (int k = 1; k <= 32; k++) begin
      s_valid = 1'($urandom); s_data = {$urandom, $urandom}; s_key = rnd256();
      @(posedge aclk);
      #1;
    end
    for (int c = 0; c < 10; c++) begin
      s_valid = 1'($urandom); s_data = {$urandom, $urandom};
      @(posedge aclk);
      #1;
      check($sformatf("hold c%0d m_valid", c), 64'(mv), 64'hf);
      check($sformatf("hold c%0d s_ready", c), 64'(sr), 64'h0);
      for (int i = 0; i < N_DUT; i++)
        check($sformatf("hold c%0d m_data U%0d", c, 1 << i), md[i], KAT_CT);
    end
    s_valid = 1'b0; m_ready = 1'b1;
    @(posedge aclk);
    #1;
    check("release s_ready", 64'(sr), 64'hf);
    check("release m_valid", 64'(mv), 64'h0);

    // Reset at round 10 of an encrypt discards the block.
    @(negedge aclk);
    s_key = KAT_KEY; s_data = KAT_PT; s_decrypt = 1'b0; s_valid = 1'b1;
    @(posedge aclk);
    #1;
    s_valid = 1'b0;
    repeat (9) @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("mid-run reset m_valid", 64'(mv), 64'h0);
    check("mid-run reset s_ready", 64'(sr), 64'h0);
    for (int i = 0; i < N_DUT; i++) check($sformatf("mid-run reset m_data U%0d", 1 << i), md[i], 64'h0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("post-reset s_ready", 64'(sr), 64'hf);
    seen_mv = '0;
    for (int k = 0; k < 40; k++) begin
      @(posedge aclk);
      #1;
      seen_mv = seen_mv | mv;
    end
    check("no m_valid after reset", 64'(seen_mv), 64'h0);
    run_block("post-reset kat", KAT_KEY, KAT_PT, 1'b0, KAT_CT);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/gost34_12_2015_magma_core.md
GOST34_12_2015_MAGMA_CORE -- requirements
Module: gost34_12_2015_magma_core

Interface
REQ-001 SHALL have parameter UNROLL, default 1, rounds computed per clock; legal values 1, 2, 4, 8; any other value SHALL fail elaboration.
REQ-002 SHALL have port aclk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port aresetn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port sbox  input  512  substitution table; nibble i (i=0..7, i=0 at bits 3:0) uses slice sbox[511-64*i -: 64]; entry j of a slice is at its bits [4j+3:4j].
REQ-005 SHALL have port s_valid  input  1  input block, key and mode valid.
REQ-006 SHALL have port s_ready  output  1  core can accept a block.
REQ-007 SHALL have port s_key  input  256  key K; K1=s_key[255:224] ... K8=s_key[31:0].
REQ-008 SHALL have port s_decrypt  input  1  0 = encrypt, 1 = decrypt.
REQ-009 SHALL have port s_data  input  64  block a1||a0; a1=[63:32], a0=[31:0].
REQ-010 SHALL have port m_valid  output  1  result valid.
REQ-011 SHALL have port m_ready  input  1  downstream accepts result.
REQ-012 SHALL have port m_data  output  64  result block.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; s_ready=1 only in IDLE; m_valid=1 only in DONE.
REQ-014 Accept on s_valid&&s_ready: latch s_data, s_key, s_decrypt; round counter r=0; go to RUN.
REQ-015 Round function g[k](a) = T(a+k mod 2^32) rotated left by 11; T applies the REQ-004 S-box to each nibble.
REQ-016 Round G[k](a1,a0) SHALL yield (a0, g[k](a0)^a1); round 32 SHALL be G*: result = (g[k](a0)^a1)||a0, no swap.
REQ-017 Encrypt key order for rounds 1..32: K1..K8 three times, then K8..K1; decrypt order: K1..K8, then K8..K1 three times.
REQ-018 RUN SHALL apply UNROLL consecutive rounds per cycle, r += UNROLL; after r reaches 32, go to DONE.
REQ-019 Latency: m_valid asserted exactly 32/UNROLL cycles after the accept edge (32, 16, 8, 4).
REQ-020 DONE: m_data stable, held until m_valid&&m_ready; then IDLE, s_ready=1 next cycle.
REQ-021 No new block accepted in RUN or DONE; s_valid there SHALL be ignored with no state change.
REQ-022 s_key, s_data, s_decrypt changes after accept SHALL NOT affect the result in flight.
REQ-023 sbox SHALL be sampled combinationally each RUN cycle; user keeps it stable from accept to m_valid.
REQ-024 m_data SHALL hold the last result after return to IDLE until the next DONE.
REQ-025 All additions modulo 2^32; carry discarded.

Reset
REQ-026 aresetn low SHALL force IDLE, r=0, s_ready=0 while asserted, m_valid=0, m_data=0, internal block/key registers=0, asynchronously.
REQ-027 Reset mid-RUN or mid-DONE SHALL discard the block; no m_valid pulse follows.
REQ-028 s_ready SHALL rise on the first aclk edge after aresetn deasserts.

Configuration
REQ-029 Macro GOST_MAGMA_DEFAULT_SBOX_EN: when defined, sbox port is ignored and the id-tc26-gost-28147-param-Z table (GOST 34.12-2015 pi0..pi7) is hardwired; when undefined, sbox port is used per REQ-004; port list identical in both builds.

Verification
REQ-030 Define GOST_MAGMA_DEFAULT_SBOX_EN, UNROLL=1, key ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, encrypt fedcba9876543210 -> m_data=4ee901e5c2d8ca3d, m_valid 32 cycles after accept.
REQ-031 Same key, decrypt 4ee901e5c2d8ca3d -> fedcba9876543210; repeat for UNROLL=2,4,8 -> identical data, latency 16, 8, 4.
REQ-032 Undefined macro, tc26-Z table driven on sbox port -> results identical to REQ-030/031.
REQ-033 Hold m_ready=0 for 10 cycles in DONE while toggling s_valid, s_data -> m_data unchanged, s_ready=0, no second accept; m_ready=1 -> s_ready=1 next cycle.
REQ-034 Assert aresetn=0 at round 10 of an encrypt -> m_valid=0, m_data=0; after release, a fresh REQ-030 block -> 4ee901e5c2d8ca3d.
